// File: rtl/shader_dispatch_ctrl.sv
// Raster-order quad scheduler for the 4-lane shader core, throttled by downstream credits.
// dbg_state exposes the FSM for checkers: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
module shader_dispatch_ctrl #(
  parameter int BITS_X   = 10,
  parameter int BITS_Y   = 9,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CREDITS  = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [1:0]        mode_in,
  input  logic              credit_ret,
  output logic [BITS_X-1:0] px_x_base,
  output logic [BITS_Y-1:0] px_y,
  output logic              valid_out,
  output logic [31:0]       time_out,
  output logic [1:0]        mode_out,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              credit_err,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int LW = $clog2(PIPE_LAT + 1);
  localparam logic [CW-1:0]     CREDIT_MAX = CW'(CREDITS);
  localparam logic [CW-1:0]     CREDIT_ONE = CW'(1);
  localparam logic [LW-1:0]     LAT_MIN    = LW'(PIPE_LAT - 1);
  localparam logic [LW-1:0]     LAT_ONE    = LW'(1);
  localparam logic [BITS_X-1:0] X_LAST     = BITS_X'(H_ACTIVE - 4);
  localparam logic [BITS_X-1:0] X_STEP     = BITS_X'(4);
  localparam logic [BITS_Y-1:0] Y_LAST     = BITS_Y'(V_ACTIVE - 1);
  localparam logic [BITS_Y-1:0] Y_STEP     = BITS_Y'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [BITS_X-1:0] cx_q, cx_d, px_x_q, px_x_d;
  logic [BITS_Y-1:0] cy_q, cy_d, px_y_q, px_y_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [31:0]       time_q, time_d;
  logic [1:0]        mode_q, mode_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic              overrun_q, overrun_d, err_q, err_d;
  logic              issue, last_quad, drain_ok;

  // valid_out has no ready: the core cannot stall, so a quad is only issued while a
  // downstream slot is known free (credit_q != 0); each credit_ret pulse frees one slot.
  assign issue     = (state_q == RUN) && (credit_q != '0);
  assign last_quad = (cx_q == X_LAST) && (cy_q == Y_LAST);
  assign drain_ok  = (lat_q == LAT_MIN) && (credit_q == CREDIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = RUN;
      RUN:     if (issue && last_quad) state_d = DRAIN;
      DRAIN:   if (drain_ok) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cx_d      = cx_q;
    cy_d      = cy_q;
    px_x_d    = px_x_q;
    px_y_d    = px_y_q;
    valid_d   = 1'b0;
    time_d    = time_q;
    mode_d    = mode_q;
    lat_d     = lat_q;
    done_d    = 1'b0;
    overrun_d = frame_start && (state_q != IDLE);
    busy_d    = (state_d == RUN) || (state_d == DRAIN);
    credit_d  = credit_q;
    err_d     = err_q;

    // A return against a full counter has no slot to give back: drop it and flag.
    if (issue && !credit_ret) begin
      credit_d = credit_q - CREDIT_ONE;
    end else if (!issue && credit_ret) begin
      if (credit_q == CREDIT_MAX) err_d = 1'b1;
      else                        credit_d = credit_q + CREDIT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          mode_d = (mode_in == 2'd3) ? 2'd1 : mode_in;
          cx_d   = '0;
          cy_d   = '0;
        end
      end
      RUN: begin
        lat_d = '0;
        if (issue) begin
          valid_d = 1'b1;
          px_x_d  = cx_q;
          px_y_d  = cy_q;
          if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = cy_q + Y_STEP;
          end else begin
            cx_d = cx_q + X_STEP;
          end
        end
      end
      DRAIN: begin
        if (lat_q != LAT_MIN) lat_d = lat_q + LAT_ONE;
      end
      DONE: begin
        done_d = 1'b1;
        time_d = time_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q      <= '0;
      cy_q      <= '0;
      px_x_q    <= '0;
      px_y_q    <= '0;
      valid_q   <= 1'b0;
      time_q    <= '0;
      mode_q    <= '0;
      lat_q     <= '0;
      credit_q  <= CREDIT_MAX;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      px_x_q    <= px_x_d;
      px_y_q    <= px_y_d;
      valid_q   <= valid_d;
      time_q    <= time_d;
      mode_q    <= mode_d;
      lat_q     <= lat_d;
      credit_q  <= credit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign px_x_base  = px_x_q;
  assign px_y       = px_y_q;
  assign valid_out  = valid_q;
  assign time_out   = time_q;
  assign mode_out   = mode_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;
  assign credit_err = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shader_dispatch_ctrl.sv
// Bench for shader_dispatch_ctrl: two small instances (8 and 2 credits) checked against a
// frame-level reference model of raster order, credit accounting and drain timing.
`timescale 1ns/1ps
module tb_shader_dispatch_ctrl;

  localparam int H = 8, V = 2, BX = 10, BY = 9;
  localparam int TOTAL = (H / 4) * V;
  localparam int CRED_A = 8, LAT_A = 1, CRED_B = 2, LAT_B = 3;

  // clock / reset / shared stimulus
  logic clk = 1'b0;
  logic rst, frame_start, credit_ret, sel;
  logic [1:0] mode_in;
  always #5 clk = ~clk;

  logic fs_a, fs_b, ret_a, ret_b;
  logic [BX-1:0] px_x_a, px_x_b, px_x_o;
  logic [BY-1:0] px_y_a, px_y_b, px_y_o;
  logic [31:0] time_a, time_b, time_o;
  logic [1:0] mode_a, mode_b, mode_o, st_a, st_b, st_o;
  logic valid_a, valid_b, valid_o, busy_a, busy_b, busy_o, done_a, done_b, done_o;
  logic ovr_a, ovr_b, ovr_o, err_a, err_b, err_o;

  assign fs_a  = frame_start & ~sel;
  assign fs_b  = frame_start & sel;
  assign ret_a = credit_ret & ~sel;
  assign ret_b = credit_ret & sel;
  assign px_x_o  = sel ? px_x_b  : px_x_a;
  assign px_y_o  = sel ? px_y_b  : px_y_a;
  assign valid_o = sel ? valid_b : valid_a;
  assign time_o  = sel ? time_b  : time_a;
  assign mode_o  = sel ? mode_b  : mode_a;
  assign busy_o  = sel ? busy_b  : busy_a;
  assign done_o  = sel ? done_b  : done_a;
  assign ovr_o   = sel ? ovr_b   : ovr_a;
  assign err_o   = sel ? err_b   : err_a;
  assign st_o    = sel ? st_b    : st_a;

  shader_dispatch_ctrl #(.BITS_X(BX), .BITS_Y(BY), .H_ACTIVE(H), .V_ACTIVE(V),
    .CREDITS(CRED_A), .PIPE_LAT(LAT_A)) u_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .mode_in(mode_in), .credit_ret(ret_a),
    .px_x_base(px_x_a), .px_y(px_y_a), .valid_out(valid_a), .time_out(time_a),
    .mode_out(mode_a), .busy(busy_a), .frame_done(done_a), .overrun(ovr_a),
    .credit_err(err_a), .dbg_state(st_a));

  shader_dispatch_ctrl #(.BITS_X(BX), .BITS_Y(BY), .H_ACTIVE(H), .V_ACTIVE(V),
    .CREDITS(CRED_B), .PIPE_LAT(LAT_B)) u_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .mode_in(mode_in), .credit_ret(ret_b),
    .px_x_base(px_x_b), .px_y(px_y_b), .valid_out(valid_b), .time_out(time_b),
    .mode_out(mode_b), .busy(busy_b), .frame_done(done_b), .overrun(ovr_b),
    .credit_err(err_b), .dbg_state(st_b));

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_time [2];
  bit exp_err;

  // driver tasks
  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; credit_ret = 1'b0; mode_in = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_time[0] = 0; exp_time[1] = 0; exp_err = 1'b0;
  endtask

  // Runs one frame on the selected instance against the reference model: quad i of the
  // frame sits at x = 4*(i mod H/4), y = i div (H/4); an issue happens on every edge
  // with a free credit; the frame ends PIPE_LAT+ cycles after the last issue once every
  // credit is back, followed by one DONE cycle.
  task automatic run_frame(input string tag, input int ret_pct, input logic [1:0] mode,
                           input int ovr_pct, input bit rand_mode, output int n_issued);
    int cmax, lat, cred, issued, drain, cyc, exp_x, exp_y;
    bit running, draining, in_done, finished, ret, fs, exp_valid, exp_busy, exp_fd;
    logic [1:0] exp_mode;
    cmax = sel ? CRED_B : CRED_A;
    lat  = sel ? LAT_B : LAT_A;
    exp_mode = (mode == 2'd3) ? 2'd1 : mode;
    cred = cmax; issued = 0; drain = 0; cyc = 0; exp_x = 0; exp_y = 0;
    running = 1'b1; draining = 1'b0; in_done = 1'b0; finished = 1'b0;
    @(negedge clk); frame_start = 1'b1; mode_in = mode; credit_ret = 1'b0;
    @(negedge clk); frame_start = 1'b0;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s start_busy got %0b want 1", tag, busy_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL %s start_valid got %0b want 0", tag, valid_o); end
    n_checks++; if (mode_o !== exp_mode) begin n_fail++; $display("FAIL %s start_mode got %0d want %0d", tag, mode_o, exp_mode); end
    while (!finished && cyc < 2000) begin
      ret = ((cmax - cred) > 0) && ($urandom_range(99) < ret_pct);
      fs  = ($urandom_range(99) < ovr_pct);
      credit_ret = ret; frame_start = fs;
      if (rand_mode) mode_in = 2'($urandom_range(3));
      exp_valid = 1'b0; exp_fd = 1'b0;
      if (in_done) begin
        exp_fd = 1'b1; in_done = 1'b0; finished = 1'b1; exp_time[sel] = exp_time[sel] + 1;
      end else if (draining) begin
        drain++;
        if (drain >= lat && cred == cmax) begin draining = 1'b0; in_done = 1'b1; end
      end else if (running && cred > 0) begin
        exp_valid = 1'b1;
        exp_x = 4 * (issued % (H / 4)); exp_y = issued / (H / 4);
        issued++;
        if (issued == TOTAL) begin running = 1'b0; draining = 1'b1; drain = 0; end
      end
      cred = cred + int'(ret) - int'(exp_valid);
      exp_busy = running || draining;
      @(negedge clk);
      n_checks++; if (valid_o !== exp_valid) begin n_fail++; $display("FAIL %s valid cyc %0d got %0b want %0b", tag, cyc, valid_o, exp_valid); end
      if (exp_valid) begin
        n_checks++; if (px_x_o !== BX'(exp_x)) begin n_fail++; $display("FAIL %s px_x got %0d want %0d", tag, px_x_o, exp_x); end
        n_checks++; if (px_y_o !== BY'(exp_y)) begin n_fail++; $display("FAIL %s px_y got %0d want %0d", tag, px_y_o, exp_y); end
      end
      n_checks++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL %s busy cyc %0d got %0b want %0b", tag, cyc, busy_o, exp_busy); end
      n_checks++; if (done_o !== exp_fd) begin n_fail++; $display("FAIL %s frame_done cyc %0d got %0b want %0b", tag, cyc, done_o, exp_fd); end
      n_checks++; if (ovr_o !== fs) begin n_fail++; $display("FAIL %s overrun cyc %0d got %0b want %0b", tag, cyc, ovr_o, fs); end
      n_checks++; if (time_o !== exp_time[sel]) begin n_fail++; $display("FAIL %s time_out got %0d want %0d", tag, time_o, exp_time[sel]); end
      n_checks++; if (mode_o !== exp_mode) begin n_fail++; $display("FAIL %s mode_out got %0d want %0d", tag, mode_o, exp_mode); end
      n_checks++; if (err_o !== exp_err) begin n_fail++; $display("FAIL %s credit_err got %0b want %0b", tag, err_o, exp_err); end
      cyc++;
    end
    frame_start = 1'b0; credit_ret = 1'b0; mode_in = 2'd0;
    n_checks++; if (!finished) begin n_fail++; $display("FAIL %s frame_timeout got %0d cycles want done", tag, cyc); end
    n_issued = issued;
  endtask

  task automatic test_reset();
    sel = 1'b0; do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      n_checks++; if ({px_x_o, px_y_o, valid_o, time_o, mode_o} !== '0) begin n_fail++; $display("FAIL reset_data got x=%0d y=%0d v=%0b t=%0d m=%0d want 0", px_x_o, px_y_o, valid_o, time_o, mode_o); end
      n_checks++; if ({busy_o, done_o, ovr_o, err_o} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %4b want 0000", {busy_o, done_o, ovr_o, err_o}); end
      n_checks++; if (st_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st_o); end
    end
  endtask

  task automatic test_raster_frame();
    int n;
    sel = 1'b0;
    run_frame("raster", 100, 2'd0, 0, 1'b0, n);
    n_checks++; if (n != TOTAL) begin n_fail++; $display("FAIL raster_count got %0d want %0d", n, TOTAL); end
    n_checks++; if (time_o !== 32'd1) begin n_fail++; $display("FAIL raster_time got %0d want 1", time_o); end
  endtask

  task automatic test_mode_latch();
    int n;
    sel = 1'b0;
    run_frame("mode2", 100, 2'd2, 0, 1'b1, n);
    run_frame("mode3", 60, 2'd3, 0, 1'b1, n);
  endtask

  task automatic test_overrun();
    int n;
    sel = 1'b0; do_reset();
    run_frame("overrun", 100, 2'd1, 100, 1'b0, n);
    n_checks++; if (n != TOTAL) begin n_fail++; $display("FAIL overrun_count got %0d want %0d", n, TOTAL); end
    @(negedge clk);
    n_checks++; if (ovr_o !== 1'b0) begin n_fail++; $display("FAIL overrun_idle got %0b want 0", ovr_o); end
    run_frame("after_overrun", 100, 2'd0, 0, 1'b0, n);
  endtask

  task automatic test_credit_throttle();
    int nv, nv2, gx, gy;
    sel = 1'b1; nv = 0; nv2 = 0; gx = -1; gy = -1;
    @(negedge clk); frame_start = 1'b1; credit_ret = 1'b0;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_o) begin
        n_checks++; if (px_x_o !== BX'(4 * nv) || px_y_o !== '0) begin n_fail++; $display("FAIL throttle_xy got (%0d,%0d) want (%0d,0)", px_x_o, px_y_o, 4 * nv); end
        nv++;
      end
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL throttle_busy got %0b want 1", busy_o); end
    end
    n_checks++; if (nv != CRED_B) begin n_fail++; $display("FAIL throttle_count got %0d want %0d", nv, CRED_B); end
    credit_ret = 1'b1;
    @(negedge clk); credit_ret = 1'b0;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL throttle_same_cycle got %0b want 0", valid_o); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o) begin nv2++; gx = int'(px_x_o); gy = int'(px_y_o); end
    end
    n_checks++; if (nv2 != 1) begin n_fail++; $display("FAIL throttle_resume got %0d want 1", nv2); end
    n_checks++; if (gx != 0 || gy != 1) begin n_fail++; $display("FAIL throttle_resume_xy got (%0d,%0d) want (0,1)", gx, gy); end
    do_reset();
  endtask

  task automatic test_credit_err();
    int nv;
    sel = 1'b1; nv = 0;
    @(negedge clk); credit_ret = 1'b1;
    @(negedge clk); credit_ret = 1'b0; exp_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", err_o); end
    end
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    n_checks++; if (nv != CRED_B) begin n_fail++; $display("FAIL err_credit_kept got %0d issues want %0d", nv, CRED_B); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_hold got %0b want 1", err_o); end
    do_reset();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear got %0b want 0", err_o); end
  endtask

  task automatic test_reset_mid_frame();
    int nv, n;
    bit seen_done;
    sel = 1'b0; nv = 0; seen_done = 1'b0;
    @(negedge clk); frame_start = 1'b1; mode_in = 2'd2;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 20 && nv < 3; i++) begin
      @(negedge clk);
      if (valid_o) nv++;
      credit_ret = valid_o;
    end
    n_checks++; if (nv != 3) begin n_fail++; $display("FAIL midrst_issues got %0d want 3", nv); end
    rst = 1'b1; credit_ret = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_time[0] = 0; exp_time[1] = 0; exp_err = 1'b0;
    n_checks++; if ({px_x_o, px_y_o, valid_o, time_o, mode_o} !== '0) begin n_fail++; $display("FAIL midrst_data got x=%0d y=%0d v=%0b t=%0d m=%0d want 0", px_x_o, px_y_o, valid_o, time_o, mode_o); end
    n_checks++; if ({busy_o, done_o, ovr_o, err_o} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags got %4b want 0000", {busy_o, done_o, ovr_o, err_o}); end
    n_checks++; if (st_o !== 2'd0) begin n_fail++; $display("FAIL midrst_state got %0d want 0", st_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done = 1'b1;
    end
    n_checks++; if (seen_done) begin n_fail++; $display("FAIL midrst_quiet got activity want none"); end
    run_frame("after_midrst", 100, 2'd1, 0, 1'b0, n);
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 12; f++) begin
      sel = 1'($urandom_range(1));
      run_frame("random", $urandom_range(100, 20), 2'($urandom_range(3)), $urandom_range(20), 1'b1, n);
      n_checks++; if (n != TOTAL) begin n_fail++; $display("FAIL random_count got %0d want %0d", n, TOTAL); end
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; credit_ret = 1'b0; mode_in = 2'd0; sel = 1'b0;
    test_reset();
    test_raster_frame();
    test_mode_latch();
    test_overrun();
    test_credit_throttle();
    test_credit_err();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
